// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, ALU op encoding and
// the decoded control bundle carried from ID into EX.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_LUI,
    ALU_PASS
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
  } id_ctrl_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID->EX pipeline bus: ID handshake and fields, held EX entry, flush,
// write-back snoop port and hazard/statistics outputs.
interface id_ex_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_imm;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [REG_ADDR_W-1:0] in_rs1_addr;
  logic [REG_ADDR_W-1:0] in_rs2_addr;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  id_ctrl_t              in_ctrl;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [XLEN-1:0]       out_imm;
  logic [XLEN-1:0]       out_rs1_data;
  logic [XLEN-1:0]       out_rs2_data;
  logic [REG_ADDR_W-1:0] out_rs1_addr;
  logic [REG_ADDR_W-1:0] out_rs2_addr;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  id_ctrl_t              out_ctrl;

  logic                  flush;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;

  logic                  load_use_stall;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_ctrl,
           out_ready, flush, wb_we, wb_addr, wb_data,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data,
           out_rs1_addr, out_rs2_addr, out_rd_addr, out_ctrl,
           load_use_stall, bubble_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_ctrl,
           out_ready, flush, wb_we, wb_addr, wb_data,
    output in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data,
           out_rs1_addr, out_rs2_addr, out_rd_addr, out_ctrl,
           load_use_stall, bubble_cnt
  );

endinterface

// File: rtl/id_ex_hazard_unit.sv
// Load-use hazard detector: a held load whose destination feeds either
// source of the instruction currently offered by ID.
module id_ex_hazard_unit (
  input  logic                           held_valid,
  input  logic                           held_mem_read,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] held_rd,
  input  logic                           in_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs1,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs2,
  output logic                           hazard
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = held_valid && held_mem_read && (held_rd != '0) && in_valid &&
                  ((held_rd == in_rs1) || (held_rd == in_rs2));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, and
// write-back refresh of operands while the entry is held.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  id_ex_reg_if.slave bus
);
  import cpu_pkg::*;

  logic            advance;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_held;
  logic [XLEN-1:0] rs2_held;

  id_ex_hazard_unit u_hazard (
    .held_valid    (bus.out_valid),
    .held_mem_read (bus.out_ctrl.mem_read),
    .held_rd       (bus.out_rd_addr),
    .in_valid      (bus.in_valid),
    .in_rs1        (bus.in_rs1_addr),
    .in_rs2        (bus.in_rs2_addr),
    .hazard        (hazard)
  );

  assign advance            = ~bus.out_valid | bus.out_ready;
  assign bus.load_use_stall = hazard & ~bus.flush;
  assign bus.in_ready       = advance & ~hazard & ~bus.flush;
  assign accept             = bus.in_valid & bus.in_ready;

  // A stalled entry's operands were read before this write-back landed
  always_comb begin
    rs1_held = bus.out_rs1_data;
    rs2_held = bus.out_rs2_data;
    if (bus.wb_we && (bus.wb_addr != '0)) begin
      if (bus.wb_addr == bus.out_rs1_addr) rs1_held = bus.wb_data;
      if (bus.wb_addr == bus.out_rs2_addr) rs2_held = bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_pc       <= '0;
      bus.out_imm      <= '0;
      bus.out_rs1_data <= '0;
      bus.out_rs2_data <= '0;
      bus.out_rs1_addr <= '0;
      bus.out_rs2_addr <= '0;
      bus.out_rd_addr  <= '0;
      bus.out_ctrl     <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_pc       <= bus.in_pc;
        bus.out_imm      <= bus.in_imm;
        bus.out_rs1_data <= bus.in_rs1_data;
        bus.out_rs2_data <= bus.in_rs2_data;
        bus.out_rs1_addr <= bus.in_rs1_addr;
        bus.out_rs2_addr <= bus.in_rs2_addr;
        bus.out_rd_addr  <= bus.in_rd_addr;
        bus.out_ctrl     <= bus.in_ctrl;
      end
    end else begin
      bus.out_rs1_data <= rs1_held;
      bus.out_rs2_data <= rs2_held;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bubble_cnt <= '0;
    end else if (hazard && bus.out_ready && !bus.flush &&
                 (bus.bubble_cnt != {CNT_W{1'b1}})) begin
      bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized and directed bench for id_ex_reg against a transaction-level
// model; a narrow-counter twin exercises bubble counter saturation.
module tb_id_ex_reg;
  import cpu_pkg::*;

  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    id_ctrl_t        ctrl;
  } entry_t;

  typedef struct {
    entry_t          ins;
    logic            out_ready;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
  } stim_t;

  localparam int CNT_W   = 16;
  localparam int SAT_W   = 2;
  localparam int CNT_MAX = 16'hFFFF;
  localparam int SAT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  int          checks   = 0;
  int          failures = 0;
  entry_t      model;
  int unsigned model_cnt;
  int unsigned model_sat_cnt;

  id_ex_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_ex_reg_if #(.XLEN(XLEN), .CNT_W(SAT_W)) sat_bus ();

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_ex_reg #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  assign sat_bus.in_valid    = bus.in_valid;
  assign sat_bus.in_pc       = bus.in_pc;
  assign sat_bus.in_imm      = bus.in_imm;
  assign sat_bus.in_rs1_data = bus.in_rs1_data;
  assign sat_bus.in_rs2_data = bus.in_rs2_data;
  assign sat_bus.in_rs1_addr = bus.in_rs1_addr;
  assign sat_bus.in_rs2_addr = bus.in_rs2_addr;
  assign sat_bus.in_rd_addr  = bus.in_rd_addr;
  assign sat_bus.in_ctrl     = bus.in_ctrl;
  assign sat_bus.out_ready   = bus.out_ready;
  assign sat_bus.flush       = bus.flush;
  assign sat_bus.wb_we       = bus.wb_we;
  assign sat_bus.wb_addr     = bus.wb_addr;
  assign sat_bus.wb_data     = bus.wb_data;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic entry_t blankEntry();
    entry_t e;
    e.valid    = 1'b0;
    e.pc       = '0;
    e.imm      = '0;
    e.rs1_data = '0;
    e.rs2_data = '0;
    e.rs1_addr = '0;
    e.rs2_addr = '0;
    e.rd_addr  = '0;
    e.ctrl     = '0;
    return e;
  endfunction

  function automatic entry_t randIns(input logic valid, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic mem_read);
    entry_t e;
    e.valid              = valid;
    e.pc                 = $urandom;
    e.imm                = $urandom;
    e.rs1_data           = $urandom;
    e.rs2_data           = $urandom;
    e.rs1_addr           = rs1;
    e.rs2_addr           = rs2;
    e.rd_addr            = rd;
    e.ctrl.alu_op        = alu_op_e'(4'($urandom_range(0, 11)));
    e.ctrl.alu_src_imm   = 1'($urandom);
    e.ctrl.mem_read      = mem_read;
    e.ctrl.mem_write     = 1'($urandom);
    e.ctrl.reg_write     = 1'($urandom);
    e.ctrl.branch        = 1'($urandom);
    e.ctrl.jump          = 1'($urandom);
    return e;
  endfunction

  function automatic stim_t mkStim(input entry_t ins, input logic out_ready, input logic flush);
    stim_t s;
    s.ins       = ins;
    s.out_ready = out_ready;
    s.flush     = flush;
    s.wb_we     = 1'b0;
    s.wb_addr   = '0;
    s.wb_data   = '0;
    return s;
  endfunction

  task automatic checkHeld();
    checkOutput("out_valid", 64'(bus.out_valid), 64'(model.valid));
    if (model.valid) begin
      checkOutput("out_pc",       64'(bus.out_pc),       64'(model.pc));
      checkOutput("out_imm",      64'(bus.out_imm),      64'(model.imm));
      checkOutput("out_rs1_data", 64'(bus.out_rs1_data), 64'(model.rs1_data));
      checkOutput("out_rs2_data", 64'(bus.out_rs2_data), 64'(model.rs2_data));
      checkOutput("out_rs1_addr", 64'(bus.out_rs1_addr), 64'(model.rs1_addr));
      checkOutput("out_rs2_addr", 64'(bus.out_rs2_addr), 64'(model.rs2_addr));
      checkOutput("out_rd_addr",  64'(bus.out_rd_addr),  64'(model.rd_addr));
      checkOutput("out_ctrl",     64'(bus.out_ctrl),     64'(model.ctrl));
    end
    checkOutput("bubble_cnt",     64'(bus.bubble_cnt),     64'(model_cnt));
    checkOutput("bubble_cnt_sat", 64'(sat_bus.bubble_cnt), 64'(model_sat_cnt));
  endtask

  // One cycle: drive, check handshake against the rules, advance the model, check the entry
  task automatic applyStimulus(input stim_t s);
    logic adv, haz, exp_ready, exp_stall;
    @(negedge clk);
    bus.in_valid    = s.ins.valid;
    bus.in_pc       = s.ins.pc;
    bus.in_imm      = s.ins.imm;
    bus.in_rs1_data = s.ins.rs1_data;
    bus.in_rs2_data = s.ins.rs2_data;
    bus.in_rs1_addr = s.ins.rs1_addr;
    bus.in_rs2_addr = s.ins.rs2_addr;
    bus.in_rd_addr  = s.ins.rd_addr;
    bus.in_ctrl     = s.ins.ctrl;
    bus.out_ready   = s.out_ready;
    bus.flush       = s.flush;
    bus.wb_we       = s.wb_we;
    bus.wb_addr     = s.wb_addr;
    bus.wb_data     = s.wb_data;
    #1;
    adv = !model.valid || s.out_ready;
    haz = model.valid && model.ctrl.mem_read && (model.rd_addr != 0) && s.ins.valid &&
          ((model.rd_addr == s.ins.rs1_addr) || (model.rd_addr == s.ins.rs2_addr));
    exp_ready = adv && !haz && !s.flush;
    exp_stall = haz && !s.flush;
    checkOutput("in_ready",       64'(bus.in_ready),       64'(exp_ready));
    checkOutput("load_use_stall", 64'(bus.load_use_stall), 64'(exp_stall));
    if (haz && s.out_ready && !s.flush) begin
      if (model_cnt < CNT_MAX) model_cnt++;
      if (model_sat_cnt < SAT_MAX) model_sat_cnt++;
    end
    if (s.flush) model.valid = 1'b0;
    else if (s.ins.valid && exp_ready) model = s.ins;
    else if (adv) model.valid = 1'b0;
    else if (s.wb_we && (s.wb_addr != 0)) begin
      if (s.wb_addr == model.rs1_addr) model.rs1_data = s.wb_data;
      if (s.wb_addr == model.rs2_addr) model.rs2_data = s.wb_data;
    end
    @(posedge clk);
    #1;
    checkHeld();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model         = blankEntry();
    model_cnt     = 0;
    model_sat_cnt = 0;
    checkOutput("rst_out_valid",    64'(bus.out_valid),    64'(0));
    checkOutput("rst_out_pc",       64'(bus.out_pc),       64'(0));
    checkOutput("rst_out_imm",      64'(bus.out_imm),      64'(0));
    checkOutput("rst_out_rs1_data", 64'(bus.out_rs1_data), 64'(0));
    checkOutput("rst_out_rs2_data", 64'(bus.out_rs2_data), 64'(0));
    checkOutput("rst_out_addrs",    64'({bus.out_rs1_addr, bus.out_rs2_addr, bus.out_rd_addr}), 64'(0));
    checkOutput("rst_out_ctrl",     64'(bus.out_ctrl),     64'(0));
    checkOutput("rst_bubble_cnt",   64'(bus.bubble_cnt),   64'(0));
    checkOutput("rst_bubble_sat",   64'(sat_bus.bubble_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    stim_t       s;
    entry_t      dep;
    int unsigned cnt_before;

    rst = 1'b1;
    model = blankEntry();
    model_cnt = 0;
    model_sat_cnt = 0;
    applyStimulus(mkStim(blankEntry(), 1'b0, 1'b0));
    resetDut();

    $display("[TB] stream");
    for (int i = 0; i < 4; i++) applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd3, 1'b0), 1'b1, 1'b0));

    $display("[TB] load-use");
    applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd5, 1'b1), 1'b1, 1'b0));
    dep = randIns(1'b1, 5'd3, 5'd5, 5'd6, 1'b0);
    applyStimulus(mkStim(dep, 1'b1, 1'b0));
    checkOutput("lu_bubble_valid", 64'(bus.out_valid),  64'(0));
    checkOutput("lu_bubble_cnt",   64'(bus.bubble_cnt), 64'(1));
    applyStimulus(mkStim(dep, 1'b1, 1'b0));
    checkOutput("lu_dep_rd",       64'(bus.out_rd_addr), 64'(6));

    $display("[TB] backpressure refresh");
    applyStimulus(mkStim(randIns(1'b1, 5'd7, 5'd8, 5'd9, 1'b0), 1'b1, 1'b0));
    s = mkStim(randIns(1'b0, 5'd0, 5'd0, 5'd0, 1'b0), 1'b0, 1'b0);
    s.wb_we = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'hDEADBEEF;
    applyStimulus(s);
    checkOutput("refresh_rs1", 64'(bus.out_rs1_data), 64'h0DEADBEEF);
    s.wb_addr = 5'd0; s.wb_data = 32'h12345678;
    applyStimulus(s);
    checkOutput("refresh_x0", 64'(bus.out_rs1_data), 64'h0DEADBEEF);
    applyStimulus(mkStim(randIns(1'b1, 5'd10, 5'd10, 5'd11, 1'b0), 1'b1, 1'b0));
    s.wb_addr = 5'd10; s.wb_data = 32'hCAFEF00D;
    applyStimulus(s);

    $display("[TB] flush priority");
    applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd3, 1'b0), 1'b0, 1'b1));
    checkOutput("flush_valid", 64'(bus.out_valid), 64'(0));

    $display("[TB] rd x0 load");
    applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd0, 1'b1), 1'b1, 1'b0));
    cnt_before = model_cnt;
    applyStimulus(mkStim(randIns(1'b1, 5'd0, 5'd4, 5'd12, 1'b0), 1'b1, 1'b0));
    checkOutput("x0_no_bubble", 64'(bus.bubble_cnt), 64'(cnt_before));

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      s = mkStim(randIns(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 11) == 0));
      s.wb_we   = 1'($urandom);
      s.wb_addr = 5'($urandom_range(0, 7));
      s.wb_data = $urandom;
      applyStimulus(s);
    end

    $display("[TB] reset mid-hold and saturation");
    applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd3, 1'b0), 1'b1, 1'b0));
    applyStimulus(mkStim(randIns(1'b1, 5'd1, 5'd2, 5'd3, 1'b0), 1'b0, 1'b0));
    resetDut();
    applyStimulus(mkStim(randIns(1'b1, 5'd0, 5'd0, 5'd5, 1'b1), 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) applyStimulus(mkStim(randIns(1'b1, 5'd5, 5'd0, 5'd5, 1'b1), 1'b1, 1'b0));
    checkOutput("sat_cnt_main", 64'(bus.bubble_cnt),     64'(5));
    checkOutput("sat_cnt_max",  64'(sat_bus.bubble_cnt), 64'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
